// File: rtl/r10k_pkg.sv
// Shared rename-state types for the R10K-style core: register counts, index widths
// and the committed architectural map type.
package r10k_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PREGS     = 64;
    localparam int AREG_W    = $clog2(ARCH_REGS);
    localparam int PREG_W    = $clog2(PREGS);
    localparam int RQ_CNT_W  = 3;

    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef preg_t [ARCH_REGS-1:0] arch_map_t;

    // Out of reset each architectural register maps to the physical register of the same index.
    function automatic arch_map_t identity_map();
        arch_map_t m;
        for (int i = 0; i < ARCH_REGS; i++) begin
            m[i] = preg_t'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/preg_ret_fifo.sv
// Small circular FIFO holding freed physical registers on their way back to the free list.
// The output reads 0 whenever the queue is empty.
module preg_ret_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    // A full queue still takes a push when the head leaves on the same edge.
    assign do_push = push_i && ((cnt_q < CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (do_pop)  head_d = ptr_inc(head_q);
        if (do_push) tail_d = ptr_inc(tail_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= data_i;
    end

    assign data_o = (cnt_q != '0) ? mem_q[head_q] : '0;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/retire_free_ctrl.sv
// Retirement side of register renaming: commits the architectural map and queues each
// overwritten mapping (T_old) for return to the free list.
module retire_free_ctrl
    import r10k_pkg::*;
#(
    parameter int ARCH_REGS = r10k_pkg::ARCH_REGS,
    parameter int PREGS     = r10k_pkg::PREGS,
    parameter int RQ_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         retire_en_i,
    input  logic                         retire_dest_vld_i,
    input  logic [$clog2(ARCH_REGS)-1:0] retire_areg_i,
    input  logic [$clog2(PREGS)-1:0]     retire_preg_i,
    output logic                         retire_rdy_o,
    output logic                         free_ret_en_o,
    output logic [$clog2(PREGS)-1:0]     free_ret_preg_o,
    output arch_map_t                    arch_map_o,
    output logic [RQ_CNT_W-1:0]          rq_cnt_o
);

    localparam int PW = $clog2(PREGS);

    arch_map_t           map_q, map_d;
    logic [RQ_CNT_W-1:0] rq_cnt;
    logic [PW-1:0]       rq_head;
    logic [PW-1:0]       t_old;
    logic                accept, map_wr;

    assign accept = rst_n && retire_en_i && retire_rdy_o;
    assign map_wr = accept && retire_dest_vld_i && (retire_areg_i != '0);
    assign t_old  = map_q[retire_areg_i];

    always_comb begin
        map_d = map_q;
        if (map_wr) map_d[retire_areg_i] = retire_preg_i;
        map_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) map_q <= identity_map();
        else        map_q <= map_d;
    end

    // The free list never stalls, so a non-empty queue drains one entry every cycle.
    preg_ret_fifo #(
        .DEPTH (RQ_DEPTH),
        .W     (PW),
        .CNT_W (RQ_CNT_W)
    ) u_ret_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (map_wr),
        .pop_i  (free_ret_en_o),
        .data_i (t_old),
        .data_o (rq_head),
        .cnt_o  (rq_cnt)
    );

    assign retire_rdy_o    = !rst_n || (rq_cnt < RQ_CNT_W'(RQ_DEPTH));
    assign free_ret_en_o   = rst_n && (rq_cnt != '0);
    assign free_ret_preg_o = rst_n ? rq_head : '0;
    assign rq_cnt_o        = rst_n ? rq_cnt : '0;
    assign arch_map_o      = map_q;

    for (genvar g = 1; g < ARCH_REGS; g++) begin : g_map_chk
    end

endmodule

// File: tb/tb_retire_free_ctrl.sv
// Bench for retire_free_ctrl: directed and random retires against a map/queue reference
// model, plus a standalone preg_ret_fifo instance driven with pops held off.
module tb_retire_free_ctrl;
    import r10k_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        retire_en_i, retire_dest_vld_i;
    logic [4:0]  retire_areg_i;
    logic [5:0]  retire_preg_i;
    logic        retire_rdy_o, free_ret_en_o;
    logic [5:0]  free_ret_preg_o;
    arch_map_t   arch_map_o;
    logic [2:0]  rq_cnt_o;

    logic        f_rst_n, f_push, f_pop;
    logic [5:0]  f_din, f_dout;
    logic [2:0]  f_cnt;

    int checks = 0;
    int errors = 0;

    logic [5:0] ref_map [32];
    logic [5:0] ref_q [$];
    logic [5:0] fq [$];

    retire_free_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .retire_en_i       (retire_en_i),
        .retire_dest_vld_i (retire_dest_vld_i),
        .retire_areg_i     (retire_areg_i),
        .retire_preg_i     (retire_preg_i),
        .retire_rdy_o      (retire_rdy_o),
        .free_ret_en_o     (free_ret_en_o),
        .free_ret_preg_o   (free_ret_preg_o),
        .arch_map_o        (arch_map_o),
        .rq_cnt_o          (rq_cnt_o)
    );

    preg_ret_fifo #(.DEPTH(4), .W(6), .CNT_W(3)) u_fifo (
        .clk    (clk),
        .rst_n  (f_rst_n),
        .push_i (f_push),
        .pop_i  (f_pop),
        .data_i (f_din),
        .data_o (f_dout),
        .cnt_o  (f_cnt)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] ref_map_vec();
        logic [191:0] v;
        for (int i = 0; i < 32; i++) v[i*6 +: 6] = ref_map[i];
        return v;
    endfunction

    function automatic logic [191:0] ident_vec();
        logic [191:0] v;
        for (int i = 0; i < 32; i++) v[i*6 +: 6] = 6'(i);
        return v;
    endfunction

    // Reference: committed map as an array, return queue as a queue that drains once per cycle.
    task automatic model_edge();
        int pre;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ref_map[i] = 6'(i);
            ref_q.delete();
        end else begin
            pre = ref_q.size();
            if (pre != 0) void'(ref_q.pop_front());
            if (retire_en_i && pre < 4 && retire_dest_vld_i && retire_areg_i != 0) begin
                ref_q.push_back(ref_map[retire_areg_i]);
                ref_map[retire_areg_i] = retire_preg_i;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rdy"}, 192'(retire_rdy_o), 192'(ref_q.size() < 4));
        chk({tag, "_en"}, 192'(free_ret_en_o), 192'(ref_q.size() != 0));
        chk({tag, "_preg"}, 192'(free_ret_preg_o), 192'((ref_q.size() != 0) ? ref_q[0] : 6'd0));
        chk({tag, "_cnt"}, 192'(rq_cnt_o), 192'(ref_q.size()));
        chk({tag, "_map"}, arch_map_o, ref_map_vec());
    endtask

    task automatic step(input string tag, input logic en, input logic vld,
                        input logic [4:0] a, input logic [5:0] p);
        retire_en_i = en; retire_dest_vld_i = vld; retire_areg_i = a; retire_preg_i = p;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic fstep(input string tag, input logic push, input logic pop, input logic [5:0] d);
        int pre;
        logic popped;
        f_push = push; f_pop = pop; f_din = d;
        @(posedge clk);
        if (!f_rst_n) fq.delete();
        else begin
            pre = fq.size();
            popped = 1'b0;
            if (pop && pre > 0) begin void'(fq.pop_front()); popped = 1'b1; end
            if (push && (pre < 4 || popped)) fq.push_back(d);
        end
        #1;
        chk({tag, "_fcnt"}, 192'(f_cnt), 192'(fq.size()));
        chk({tag, "_fdata"}, 192'(f_dout), 192'((fq.size() != 0) ? fq[0] : 6'd0));
    endtask

    initial begin
        rst_n = 1'b0; retire_en_i = 1'b0; retire_dest_vld_i = 1'b0;
        retire_areg_i = '0; retire_preg_i = '0;
        f_rst_n = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_din = '0;

        step("rst0", 1'b0, 1'b0, 5'd0, 6'd0);
        step("rst1", 1'b1, 1'b1, 5'd4, 6'd50);
        chk("rst_map_ident", arch_map_o, ident_vec());
        rst_n = 1'b1;

        step("r031", 1'b1, 1'b1, 5'd5, 6'd40);
        chk("r031_en", 192'(free_ret_en_o), 192'(1));
        chk("r031_preg", 192'(free_ret_preg_o), 192'(5));
        chk("r031_map5", 192'(arch_map_o[5]), 192'(40));
        step("idle", 1'b0, 1'b0, 5'd0, 6'd0);
        chk("idle_en", 192'(free_ret_en_o), 192'(0));

        step("r032a", 1'b1, 1'b1, 5'd0, 6'd33);
        chk("r032a_en", 192'(free_ret_en_o), 192'(0));
        chk("r032a_map0", 192'(arch_map_o[0]), 192'(0));
        step("r032b", 1'b1, 1'b0, 5'd9, 6'd50);
        chk("r032b_en", 192'(free_ret_en_o), 192'(0));
        chk("r032b_map9", 192'(arch_map_o[9]), 192'(9));

        step("r033a", 1'b1, 1'b1, 5'd3, 6'd41);
        chk("r033a_preg", 192'(free_ret_preg_o), 192'(3));
        step("r033b", 1'b1, 1'b1, 5'd3, 6'd42);
        chk("r033b_preg", 192'(free_ret_preg_o), 192'(41));
        chk("r033b_map3", 192'(arch_map_o[3]), 192'(42));
        step("idle", 1'b0, 1'b0, 5'd0, 6'd0);

        for (int i = 0; i < 6; i++) begin
            step("r034", 1'b1, 1'b1, 5'(10 + i), 6'(43 + i));
            chk("r034_order", 192'(free_ret_preg_o), 192'(10 + i));
            chk("r034_cnt_le1", 192'(rq_cnt_o <= 3'd1), 192'(1));
        end
        step("idle", 1'b0, 1'b0, 5'd0, 6'd0);

        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 40) != 0);
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                 5'($urandom), 6'($urandom));
        end
        rst_n = 1'b1;

        step("r028q", 1'b1, 1'b1, 5'd7, 6'd60);
        rst_n = 1'b0; retire_en_i = 1'b1; retire_dest_vld_i = 1'b1;
        retire_areg_i = 5'd8; retire_preg_i = 6'd61;
        #1;
        chk("rstdur_rdy", 192'(retire_rdy_o), 192'(1));
        chk("rstdur_en", 192'(free_ret_en_o), 192'(0));
        chk("rstdur_preg", 192'(free_ret_preg_o), 192'(0));
        chk("rstdur_cnt", 192'(rq_cnt_o), 192'(0));
        @(posedge clk);
        model_edge();
        #1;
        check_model("rst_mid");
        chk("rst_mid_ident", arch_map_o, ident_vec());
        rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0, 5'd0, 6'd0);

        fstep("f_rst", 1'b0, 1'b0, 6'd0);
        f_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) fstep("f_fill", 1'b1, 1'b0, 6'(20 + i));
        chk("f_full_cnt", 192'(f_cnt), 192'(4));
        fstep("f_full_push", 1'b1, 1'b0, 6'd50);
        chk("f_full_drop", 192'(f_cnt), 192'(4));
        for (int i = 0; i < 3; i++) fstep("f_pushpop", 1'b1, 1'b1, 6'(51 + i));
        for (int i = 0; i < 80; i++)
            fstep("f_rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 6'($urandom));
        for (int i = 0; i < 5; i++) fstep("f_drain", 1'b0, 1'b1, 6'd0);
        for (int i = 0; i < 3; i++) fstep("f_q3", 1'b1, 1'b0, 6'(30 + i));
        chk("r036_cnt3", 192'(f_cnt), 192'(3));
        f_rst_n = 1'b0;
        fstep("r036", 1'b1, 1'b0, 6'd9);
        chk("r036_cnt0", 192'(f_cnt), 192'(0));
        chk("r036_data0", 192'(f_dout), 192'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
